// File: rtl/bus_arbiter.sv
// Round-robin arbiter handing the system bus from the CPU to two requesters (m0 = PRC, m1 = aux DMA).
// Optional grant watchdog enabled by defining BUS_ARB_WATCHDOG_EN.
// state    | meaning
// IDLE     | CPU owns the bus
// WAIT_ACK | bus requested from CPU, waiting for release
// GRANTED  | requester cur owns the bus
// HANDOFF  | dead cycle between requesters
// RELEASE  | dead cycle before returning the bus to the CPU
module bus_arbiter #(
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic        cpu_bus_request,
  input  logic        cpu_bus_ack,
  input  logic [23:0] cpu_address_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_bus_status,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [47:0] req_address,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_read,
  input  logic [1:0]  req_write,
  input  logic [3:0]  req_bus_status,
  output logic [23:0] address_out,
  output logic [7:0]  data_out,
  output logic        read,
  output logic        write,
  output logic [1:0]  bus_status,
  output logic [1:0]  owner,
  output logic        watchdog_irq
);

  typedef enum logic [2:0] {IDLE, WAIT_ACK, GRANTED, HANDOFF, RELEASE} state_t;

  state_t     state, state_nxt;
  logic       cur, cur_nxt;
  logic       rr_prio;
  logic [1:0] mask, mask_set;
  logic [1:0] req_eff;
  logic [1:0] gnt_q;
  logic       wd_hit;

  // A requester whose grant was taken away must drop req before it competes again.
  assign req_eff = req & ~mask;

`ifdef BUS_ARB_WATCHDOG_EN
  localparam int WD_W = (WATCHDOG_CYCLES > 2) ? $clog2(WATCHDOG_CYCLES) : 1;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_irq_q;

  assign wd_hit       = (state == GRANTED) && (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));
  assign watchdog_irq = wd_irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt   <= '0;
      wd_irq_q <= 1'b0;
    end else begin
      wd_irq_q <= wd_hit && cpu_bus_ack && req_eff[cur];
      if (state_nxt == GRANTED && state != GRANTED) wd_cnt <= '0;
      else if (state == GRANTED)                    wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign wd_hit       = 1'b0;
  assign watchdog_irq = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cur     <= 1'b0;
      rr_prio <= 1'b0;
      mask    <= 2'b00;
      gnt_q   <= 2'b00;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      mask  <= req & (mask | mask_set);
      gnt_q <= (state_nxt == GRANTED) ? (cur_nxt ? 2'b10 : 2'b01) : 2'b00;
      if (state_nxt == GRANTED && state != GRANTED) rr_prio <= ~cur_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    mask_set  = 2'b00;
    case (state)
      IDLE:     if (|req_eff) state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (req_eff == 2'b00) state_nxt = RELEASE;
        else if (cpu_bus_ack) begin
          state_nxt = GRANTED;
          cur_nxt   = (req_eff == 2'b11) ? rr_prio : req_eff[1];
        end
      end
      GRANTED: begin
        if (!cpu_bus_ack) begin
          state_nxt     = RELEASE;
          mask_set[cur] = req[cur];
        end else if (!req[cur] || wd_hit) begin
          mask_set[cur] = req[cur];
          state_nxt     = req_eff[~cur] ? HANDOFF : RELEASE;
        end
      end
      HANDOFF: begin
        if (req_eff[~cur]) begin
          state_nxt = GRANTED;
          cur_nxt   = ~cur;
        end else state_nxt = RELEASE;
      end
      RELEASE:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    address_out = cpu_address_in;
    data_out    = cpu_data_in;
    read        = cpu_read;
    write       = cpu_write;
    bus_status  = cpu_bus_status;
    owner       = 2'b00;
    case (state)
      GRANTED: begin
        address_out = cur ? req_address[47:24]   : req_address[23:0];
        data_out    = cur ? req_data[15:8]       : req_data[7:0];
        read        = cur ? req_read[1]          : req_read[0];
        write       = cur ? req_write[1]         : req_write[0];
        bus_status  = cur ? req_bus_status[3:2]  : req_bus_status[1:0];
        owner       = cur ? 2'b10 : 2'b01;
      end
      HANDOFF, RELEASE: begin
        address_out = '0;
        data_out    = '0;
        read        = 1'b0;
        write       = 1'b0;
        bus_status  = 2'b00;
        owner       = 2'b11;
      end
      default: ;
    endcase
    // The CPU keeps the bus while reset is held, whatever state the register shows.
    if (reset) begin
      address_out = cpu_address_in;
      data_out    = cpu_data_in;
      read        = cpu_read;
      write       = cpu_write;
      bus_status  = cpu_bus_status;
    end
  end

  assign cpu_bus_request = (state != IDLE);
  assign gnt             = gnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; watchdog scenario depends on BUS_ARB_WATCHDOG_EN.
module tb_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_bus_request;
  logic        cpu_bus_ack;
  logic [23:0] cpu_address_in;
  logic [7:0]  cpu_data_in;
  logic        cpu_read, cpu_write;
  logic [1:0]  cpu_bus_status;
  logic [1:0]  req, gnt;
  logic [47:0] req_address;
  logic [15:0] req_data;
  logic [1:0]  req_read, req_write;
  logic [3:0]  req_bus_status;
  logic [23:0] address_out;
  logic [7:0]  data_out;
  logic        read, write;
  logic [1:0]  bus_status, owner;
  logic        watchdog_irq;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.WATCHDOG_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .cpu_bus_request(cpu_bus_request), .cpu_bus_ack(cpu_bus_ack),
    .cpu_address_in(cpu_address_in), .cpu_data_in(cpu_data_in), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_bus_status(cpu_bus_status), .req(req), .gnt(gnt),
    .req_address(req_address), .req_data(req_data), .req_read(req_read), .req_write(req_write),
    .req_bus_status(req_bus_status), .address_out(address_out), .data_out(data_out),
    .read(read), .write(write), .bus_status(bus_status), .owner(owner),
    .watchdog_irq(watchdog_irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; cpu_bus_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b11; cpu_bus_ack = 1'b1;
    tick(); tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    checks++; if (cpu_bus_request !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", cpu_bus_request); end
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner got=%b exp=00", owner); end
    checks++; if (watchdog_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", watchdog_irq); end
    checks++; if (address_out !== 24'hC0FFEE) begin errors++; $display("FAIL reset_addr got=%h exp=c0ffee", address_out); end
    checks++; if (write !== 1'b0 || read !== 1'b1) begin errors++; $display("FAIL reset_rw got=%b%b exp=10", read, write); end
    reset = 1'b0; req = 2'b00; cpu_bus_ack = 1'b0;
    tick();
  endtask

  task automatic test_single_grant();
    do_reset();
    req = 2'b01;
    tick();
    checks++; if (cpu_bus_request !== 1'b1) begin errors++; $display("FAIL single_busreq_c1 got=%b exp=1", cpu_bus_request); end
    checks++; if (owner !== 2'b00 || address_out !== 24'hC0FFEE) begin errors++; $display("FAIL single_waitack_cpu owner=%b addr=%h exp=00/c0ffee", owner, address_out); end
    tick(); tick();
    cpu_bus_ack = 1'b1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL single_gnt_c3 got=%b exp=00", gnt); end
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt_c4 got=%b exp=01", gnt); end
    checks++; if (address_out !== 24'h001000 || data_out !== 8'hA1) begin errors++; $display("FAIL single_bus addr=%h data=%h exp=001000/a1", address_out, data_out); end
    checks++; if (owner !== 2'b01 || read !== 1'b1 || bus_status !== 2'b01) begin errors++; $display("FAIL single_owner owner=%b read=%b st=%b exp=01/1/01", owner, read, bus_status); end
    req = 2'b00;
    tick();
    checks++; if (owner !== 2'b11 || read !== 1'b0 || gnt !== 2'b00 || cpu_bus_request !== 1'b1) begin errors++; $display("FAIL single_release owner=%b read=%b gnt=%b breq=%b exp=11/0/00/1", owner, read, gnt, cpu_bus_request); end
    tick();
    checks++; if (cpu_bus_request !== 1'b0 || owner !== 2'b00 || address_out !== 24'hC0FFEE) begin errors++; $display("FAIL single_idle breq=%b owner=%b addr=%h exp=0/00/c0ffee", cpu_bus_request, owner, address_out); end
  endtask

  task automatic test_handoff();
    do_reset();
    cpu_bus_ack = 1'b1; req = 2'b11;
    tick();
    checks++; if (cpu_bus_request !== 1'b1 || gnt !== 2'b00) begin errors++; $display("FAIL handoff_wait breq=%b gnt=%b exp=1/00", cpu_bus_request, gnt); end
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL handoff_first got=%b exp=01", gnt); end
    tick(); tick(); tick(); tick();
    checks++; if (gnt !== 2'b01 || owner !== 2'b01) begin errors++; $display("FAIL handoff_hold gnt=%b owner=%b exp=01/01", gnt, owner); end
    req = 2'b10;
    tick();
    checks++; if (gnt !== 2'b00 || owner !== 2'b11) begin errors++; $display("FAIL handoff_dead gnt=%b owner=%b exp=00/11", gnt, owner); end
    checks++; if (read !== 1'b0 || write !== 1'b0 || bus_status !== 2'b00 || cpu_bus_request !== 1'b1) begin errors++; $display("FAIL handoff_dead_bus r=%b w=%b st=%b breq=%b exp=0/0/00/1", read, write, bus_status, cpu_bus_request); end
    tick();
    checks++; if (gnt !== 2'b10 || owner !== 2'b10) begin errors++; $display("FAIL handoff_second gnt=%b owner=%b exp=10/10", gnt, owner); end
    checks++; if (address_out !== 24'h002000 || write !== 1'b1 || data_out !== 8'hB2) begin errors++; $display("FAIL handoff_m1_bus addr=%h w=%b data=%h exp=002000/1/b2", address_out, write, data_out); end
    req = 2'b00;
    tick(); tick();
    checks++; if (cpu_bus_request !== 1'b0) begin errors++; $display("FAIL handoff_idle breq=%b exp=0", cpu_bus_request); end
  endtask

  task automatic test_round_robin();
    // m1 was served last by test_handoff
    cpu_bus_ack = 1'b1; req = 2'b11;
    tick(); tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rr_after_m1 got=%b exp=01", gnt); end
    req = 2'b10;
    tick(); tick();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rr_handoff_m1 got=%b exp=10", gnt); end
    req = 2'b00;
    tick(); tick();
    req = 2'b01;
    tick(); tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rr_m0_alone got=%b exp=01", gnt); end
    req = 2'b00;
    tick(); tick();
    req = 2'b11;
    tick(); tick();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rr_after_m0 got=%b exp=10", gnt); end
    req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_ack_drop();
    do_reset();
    cpu_bus_ack = 1'b1; req = 2'b01;
    tick(); tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL ackdrop_grant got=%b exp=01", gnt); end
    cpu_bus_ack = 1'b0;
    tick();
    checks++; if (gnt !== 2'b00 || owner !== 2'b11 || cpu_bus_request !== 1'b1) begin errors++; $display("FAIL ackdrop_release gnt=%b owner=%b breq=%b exp=00/11/1", gnt, owner, cpu_bus_request); end
    tick();
    checks++; if (cpu_bus_request !== 1'b0 || owner !== 2'b00) begin errors++; $display("FAIL ackdrop_idle breq=%b owner=%b exp=0/00", cpu_bus_request, owner); end
    tick();
    checks++; if (cpu_bus_request !== 1'b0) begin errors++; $display("FAIL ackdrop_masked breq=%b exp=0", cpu_bus_request); end
    req = 2'b00;
    tick();
    req = 2'b01;
    tick();
    checks++; if (cpu_bus_request !== 1'b1) begin errors++; $display("FAIL ackdrop_rerequest breq=%b exp=1", cpu_bus_request); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    cpu_bus_ack = 1'b1; req = 2'b10;
    tick(); tick();
    checks++; if (write !== 1'b1 || gnt !== 2'b10) begin errors++; $display("FAIL midrst_pre w=%b gnt=%b exp=1/10", write, gnt); end
    reset = 1'b1;
    #1;
    checks++; if (write !== 1'b0 || address_out !== 24'hC0FFEE) begin errors++; $display("FAIL midrst_follow w=%b addr=%h exp=0/c0ffee", write, address_out); end
    tick();
    checks++; if (gnt !== 2'b00 || cpu_bus_request !== 1'b0 || owner !== 2'b00) begin errors++; $display("FAIL midrst_after gnt=%b breq=%b owner=%b exp=00/0/00", gnt, cpu_bus_request, owner); end
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL midrst_write got=%b exp=0", write); end
    reset = 1'b0; req = 2'b00;
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    cpu_bus_ack = 1'b1; req = 2'b01;
    tick(); tick();
`ifdef BUS_ARB_WATCHDOG_EN
    repeat (15) tick();
    checks++; if (gnt !== 2'b01 || watchdog_irq !== 1'b0) begin errors++; $display("FAIL wd_16th gnt=%b irq=%b exp=01/0", gnt, watchdog_irq); end
    tick();
    checks++; if (watchdog_irq !== 1'b1 || gnt !== 2'b00) begin errors++; $display("FAIL wd_fire irq=%b gnt=%b exp=1/00", watchdog_irq, gnt); end
    tick();
    checks++; if (watchdog_irq !== 1'b0 || cpu_bus_request !== 1'b0) begin errors++; $display("FAIL wd_after irq=%b breq=%b exp=0/0", watchdog_irq, cpu_bus_request); end
    tick(); tick();
    checks++; if (cpu_bus_request !== 1'b0 || gnt !== 2'b00) begin errors++; $display("FAIL wd_masked breq=%b gnt=%b exp=0/00", cpu_bus_request, gnt); end
    req = 2'b00;
    tick();
    req = 2'b01;
    tick(); tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL wd_regrant got=%b exp=01", gnt); end
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++; if (watchdog_irq !== 1'b0) begin errors++; $display("FAIL nowd_irq cycle=%0d got=%b exp=0", i, watchdog_irq); end
    end
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL nowd_hold got=%b exp=01", gnt); end
`endif
    req = 2'b00;
    tick(); tick();
  endtask

  initial begin
    reset = 1'b1;
    cpu_bus_ack = 1'b0;
    cpu_address_in = 24'hC0FFEE; cpu_data_in = 8'h5C;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_bus_status = 2'b10;
    req = 2'b00;
    req_address = {24'h002000, 24'h001000};
    req_data = {8'hB2, 8'hA1};
    req_read = 2'b01; req_write = 2'b10;
    req_bus_status = 4'b1101;
    test_reset();
    test_single_grant();
    test_handoff();
    test_round_robin();
    test_ack_drop();
    test_reset_mid_grant();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
